// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and widths for the data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_BE_W   = 4;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_sram_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sram_array
// Description : Single-port synchronous RAM, per-byte write enables,
//               registered read, no reset on contents or read register.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [DMEM_BE_W-1:0]   be,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] r_mem [DEPTH];
  logic [DMEM_WORD_W-1:0] r_rdata;

  // The read register only updates on loads so the last loaded word persists.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DMEM_BE_W; i++) begin
          if (be[i]) begin
            r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Data-memory controller: request capture, wait-state FSM,
//               range check and byte-enabled SRAM access.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dmem_req,
  input  logic                   dmem_we,
  input  logic [31:0]            dmem_addr,
  input  logic [DMEM_BE_W-1:0]   dmem_be,
  input  logic [DMEM_WORD_W-1:0] dmem_wdata,
  output logic [DMEM_WORD_W-1:0] dmem_rdata,
  output logic                   dmem_ready,
  output logic                   dmem_err,
  output logic                   busy
);

  localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DMEM_CNT_W-1:0] c_wait_load =
    (WAIT_STATES > 0) ? DMEM_CNT_W'(WAIT_STATES - 1) : '0;

  dmem_state_t            r_state;
  dmem_state_t            w_next_state;
  logic [DMEM_CNT_W-1:0]  r_cnt;
  logic                   r_we;
  logic [29:0]            r_widx;
  logic [DMEM_BE_W-1:0]   r_be;
  logic [DMEM_WORD_W-1:0] r_wdata;
  logic                   r_err;
  logic                   r_rdata_zero;

  logic                   w_acc_we;
  logic [29:0]            w_acc_widx;
  logic [DMEM_BE_W-1:0]   w_acc_be;
  logic [DMEM_WORD_W-1:0] w_acc_wdata;
  logic                   w_in_range;
  logic                   w_enter_resp;
  logic [DMEM_WORD_W-1:0] w_sram_rdata;
  logic                   w_unused;

  // With zero wait states the access edge is also the capture edge, so the
  // live bus feeds the array while in IDLE.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_widx  = r_widx;
    w_acc_be    = r_be;
    w_acc_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_acc_we    = dmem_we;
      w_acc_widx  = dmem_addr[31:2];
      w_acc_be    = dmem_be;
      w_acc_wdata = dmem_wdata;
    end
  end

  // Full 30-bit index is compared so high addresses cannot alias low words.
  assign w_in_range   = {2'b00, w_acc_widx} < 32'(DEPTH_WORDS);
  assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (dmem_req) begin
          w_next_state = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_widx       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_rdata_zero <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && dmem_req) begin
        r_cnt   <= c_wait_load;
        r_we    <= dmem_we;
        r_widx  <= dmem_addr[31:2];
        r_be    <= dmem_be;
        r_wdata <= dmem_wdata;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - DMEM_CNT_W'(1);
      end
      if (w_enter_resp) begin
        r_err <= !w_in_range;
        if (!w_acc_we) begin
          r_rdata_zero <= !w_in_range;
        end
      end
    end
  end

  dmem_sram_array #(
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (c_idx_w)
  ) u_sram (
    .clk   (clk),
    .en    (w_enter_resp && w_in_range),
    .we    (w_acc_we),
    .be    (w_acc_be),
    .addr  (w_acc_widx[c_idx_w-1:0]),
    .wdata (w_acc_wdata),
    .rdata (w_sram_rdata)
  );

  // Out-of-range loads and the post-reset state present zero without
  // touching the array's read register.
  assign dmem_rdata = r_rdata_zero ? '0 : w_sram_rdata;
  assign dmem_ready = (r_state == RESP);
  assign dmem_err   = (r_state == RESP) && r_err;
  assign busy       = (r_state != IDLE);

  assign w_unused = ^dmem_addr[1:0];

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench; three controllers (0, 1, 3 wait states)
//               checked against a word/byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int N     = 3;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req   [N];
  logic        we    [N];
  logic [31:0] addr  [N];
  logic [3:0]  be    [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];
  logic        ready [N];
  logic        err   [N];
  logic        busy  [N];

  logic [31:0] mdl_mem   [N][DEPTH];
  logic [3:0]  mdl_bk    [N][DEPTH];
  logic [31:0] mdl_rdata [N];
  bit          rd_known  [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      dmem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES ((gi == 0) ? 0 : ((gi == 1) ? 1 : 3))
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_req   (req[gi]),
        .dmem_we    (we[gi]),
        .dmem_addr  (addr[gi]),
        .dmem_be    (be[gi]),
        .dmem_wdata (wdata[gi]),
        .dmem_rdata (rdata[gi]),
        .dmem_ready (ready[gi]),
        .dmem_err   (err[gi]),
        .busy       (busy[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH);
  endfunction

  // Apply the architectural effect of one completed access to the model.
  task automatic mdl_apply(input int k, input bit t_we, input logic [31:0] t_addr,
                           input logic [3:0] t_be, input logic [31:0] t_wdata);
    int idx;
    idx = int'(t_addr >> 2);
    if (t_we) begin
      if (!is_oor(t_addr)) begin
        for (int b = 0; b < 4; b++) begin
          if (t_be[b]) begin
            mdl_mem[k][idx][8*b +: 8] = t_wdata[8*b +: 8];
            mdl_bk[k][idx][b] = 1'b1;
          end
        end
      end
    end else if (is_oor(t_addr)) begin
      mdl_rdata[k] = '0;
      rd_known[k]  = 1'b1;
    end else begin
      mdl_rdata[k] = mdl_mem[k][idx];
      rd_known[k]  = (mdl_bk[k][idx] == 4'hf);
    end
  endtask

  task automatic txn(input int k, input bit t_we, input logic [31:0] t_addr,
                     input logic [3:0] t_be, input logic [31:0] t_wdata, input bit perturb);
    int lat;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy[k]), 32'd0);
    req[k] = 1'b1; we[k] = t_we; addr[k] = t_addr; be[k] = t_be; wdata[k] = t_wdata;
    lat = 0;
    while (!ready[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (perturb && !ready[k]) begin
        we[k] = ~t_we; addr[k] = t_addr + 32'd4; be[k] = ~t_be; wdata[k] = $urandom;
      end
    end
    chk("latency", 32'(lat), 32'(ws_of(k) + 1));
    chk("resp_busy", 32'(busy[k]), 32'd1);
    chk("err", 32'(err[k]), 32'(is_oor(t_addr)));
    mdl_apply(k, t_we, t_addr, t_be, t_wdata);
    if (rd_known[k]) chk("rdata", rdata[k], mdl_rdata[k]);
    req[k] = 1'b0;
    @(posedge clk); #1;
    chk("ready_pulse", 32'(ready[k]), 32'd0);
  endtask

  // Request held high for several back-to-back loads.
  task automatic burst(input int k, input logic [31:0] t_addr);
    int last, cycle, npulse, lowcnt;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = 1'b0; addr[k] = t_addr; be[k] = 4'hf; wdata[k] = '0;
    last = -1; cycle = 0; npulse = 0; lowcnt = 0;
    while (npulse < 4 && cycle < 100) begin
      @(posedge clk); #1;
      cycle++;
      if (!busy[k]) lowcnt++;
      if (ready[k]) begin
        if (last >= 0) begin
          chk("period", 32'(cycle - last), 32'(ws_of(k) + 2));
          chk("busy_gap", 32'(lowcnt), 32'd1);
        end else begin
          chk("burst_lat", 32'(cycle), 32'(ws_of(k) + 1));
        end
        last = cycle; npulse++; lowcnt = 0;
      end
    end
    chk("burst_pulses", 32'(npulse), 32'd4);
    req[k] = 1'b0;
    mdl_apply(k, 1'b0, t_addr, 4'hf, '0);
    if (rd_known[k]) chk("burst_rdata", rdata[k], mdl_rdata[k]);
  endtask

  // Store interrupted by reset, either during WAIT or during RESP.
  task automatic reset_store(input int k, input logic [31:0] t_addr,
                             input logic [31:0] t_wdata, input bit in_resp);
    int n;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = 1'b1; addr[k] = t_addr; be[k] = 4'hf; wdata[k] = t_wdata;
    @(posedge clk); #1;
    n = 1;
    if (in_resp) begin
      while (!ready[k] && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("rst_resp_ready", 32'(ready[k]), 32'd1);
    end else begin
      chk("rst_wait_state", 32'(busy[k] && !ready[k]), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready[k]), 32'd0);
    chk("rst_err", 32'(err[k]), 32'd0);
    chk("rst_busy", 32'(busy[k]), 32'd0);
    chk("rst_rdata", rdata[k], 32'd0);
    req[k] = 1'b0;
    #1;
    rst = 1'b0;
    if (in_resp) mdl_apply(k, 1'b1, t_addr, 4'hf, t_wdata);
    for (int j = 0; j < N; j++) begin
      mdl_rdata[j] = '0;
      rd_known[j]  = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
      mdl_rdata[k] = '0; rd_known[k] = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mdl_mem[k][i] = '0;
        mdl_bk[k][i]  = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("reset_rdata", rdata[k], 32'd0);
      chk("reset_ready", 32'(ready[k]), 32'd0);
      chk("reset_err", 32'(err[k]), 32'd0);
      chk("reset_busy", 32'(busy[k]), 32'd0);
    end
    rst = 1'b0;

    // Word store then load, byte-enable merge, out-of-range on one wait state.
    txn(1, 1'b1, 32'h10, 4'hf, 32'hDEADBEEF, 1'b0);
    txn(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    chk("lw_10", rdata[1], 32'hDEADBEEF);
    txn(1, 1'b1, 32'h20, 4'hf, 32'h11223344, 1'b0);
    txn(1, 1'b1, 32'h20, 4'b1010, 32'hAA00BB00, 1'b0);
    txn(1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    chk("be_merge", rdata[1], 32'hAA22BB44);
    txn(1, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 1'b0);
    txn(1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    chk("be_none", rdata[1], 32'hAA22BB44);
    txn(1, 1'b1, 32'h0, 4'hf, 32'h12345678, 1'b0);
    txn(1, 1'b0, 32'h1000, 4'hf, 32'h0, 1'b0);
    chk("oor_rdata", rdata[1], 32'h0);
    txn(1, 1'b1, 32'h1000, 4'hf, 32'hFFFFFFFF, 1'b0);
    txn(1, 1'b0, 32'h0, 4'hf, 32'h0, 1'b0);
    chk("no_alias", rdata[1], 32'h12345678);

    // Fields change during WAIT; rdata must survive a following store.
    txn(1, 1'b1, 32'h14, 4'hf, 32'h55555555, 1'b0);
    txn(1, 1'b0, 32'h10, 4'hf, 32'h0, 1'b1);
    chk("field_hold", rdata[1], 32'hDEADBEEF);
    txn(1, 1'b1, 32'h14, 4'hf, 32'h66666666, 1'b0);
    chk("rdata_hold", rdata[1], 32'hDEADBEEF);

    // Reset during WAIT drops the store; reset during RESP keeps it.
    txn(1, 1'b1, 32'h40, 4'hf, 32'hCAFEF00D, 1'b0);
    reset_store(1, 32'h40, 32'h0BADBEEF, 1'b0);
    txn(1, 1'b0, 32'h40, 4'hf, 32'h0, 1'b0);
    chk("rst_no_write", rdata[1], 32'hCAFEF00D);
    reset_store(2, 32'h44, 32'hFACEB00C, 1'b1);
    txn(2, 1'b0, 32'h44, 4'hf, 32'h0, 1'b0);
    chk("rst_after_write", rdata[2], 32'hFACEB00C);

    // Latency and throughput with requests held high.
    for (int k = 0; k < N; k++) begin
      txn(k, 1'b1, 32'h8, 4'hf, 32'h01020304 + 32'(k), 1'b0);
      burst(k, 32'h8);
    end

    // Randomized traffic on every instance.
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 40; t++) begin
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = $urandom | 32'h1000;
        else a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        txn(k, 1'($urandom), a, 4'($urandom), $urandom, 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the pipeline's memory-access stage.
- Consumes its word-aligned request bus (req/we/addr/be/wdata) and returns read data plus a ready pulse.
- Serves requests from an internal byte-enabled synchronous SRAM with a configurable number of wait states.
- Flags out-of-range addresses so the core can stall or trap.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >= 2)
WAIT_STATES, 1, extra cycles inserted between request capture and response (0..15)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
dmem_req  input  1  request valid; held stable with all request fields until dmem_ready
dmem_we  input  1  1 = store, 0 = load
dmem_addr  input  32  word-aligned byte address; bits [1:0] ignored
dmem_be  input  4  byte enables for stores; ignored for loads
dmem_wdata  input  32  lane-aligned store data
dmem_rdata  output  32  full read word, registered
dmem_ready  output  1  one-cycle response pulse
dmem_err  output  1  asserted with dmem_ready when the address is out of range
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE; dmem_rdata=0; dmem_ready=0; dmem_err=0; busy=0; wait counter=0.
- Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dmem_req=1, capture we, addr[31:2], be and wdata into request registers.
  - Next state: WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else RESP.
- WAIT:
  - Counter decrements each cycle.
  - When counter==0, next state is RESP.
  - Array access (read and/or write) occurs on the clock edge that enters RESP.
- RESP:
  - dmem_ready=1 for exactly one cycle, combinationally decoded from state.
  - Next state is IDLE unconditionally.
  - A request present in the following IDLE cycle is treated as new.
- Latency: dmem_req high in IDLE at cycle T -> dmem_ready high in cycle T+1+WAIT_STATES.
  - Throughput: one access every WAIT_STATES+2 cycles.
- Range check on captured word index: index >= DEPTH_WORDS means out of range.
  - Out of range: no write; dmem_rdata loaded with 0; dmem_err=1 in the RESP cycle.
  - In range: dmem_err=0.
- Loads:
  - dmem_rdata loaded with array[index] on entering RESP.
  - dmem_rdata holds its value until the next load completes; stores do not change it.
- Stores:
  - Only bytes with be[i]=1 are written: byte i takes wdata[8i+7:8i].
  - be=4'b0000 is a legal no-op store that still completes with ready.
- Request fields are sampled only in IDLE. Changes while busy are ignored.
- Deasserting dmem_req while busy does not abort; the access completes.
- Reset mid-operation (WAIT or RESP):
  - Returns immediately to IDLE; outputs go to their reset values.
  - A write commits only if its RESP-entry edge preceded reset assertion.
- Index width is clog2(DEPTH_WORDS). Comparison uses the full addr[31:2] so high-address aliasing is impossible.

Decomposition:
- Shared package dmem_pkg:
  - dmem_state_t enum {IDLE, WAIT, RESP}
  - DMEM_WORD_W=32, DMEM_BE_W=4
  - wait-counter width constant (4 bits)
- Sub-module dmem_sram_array: single-port synchronous RAM with per-byte write enables and registered read, no reset.
  - Instantiated once; controller FSM, counter and range check stay in dmem_ctrl.

Test Plan:
1. Reset: assert rst mid-WAIT with a store pending -> next cycle state IDLE, ready/err/busy/rdata=0; later load of that address shows no write occurred.
2. Word store then load, WAIT_STATES=1:
   - SW addr 0x10, wdata 0xDEADBEEF, be 1111 -> ready in cycle T+2, err=0.
   - LW addr 0x10 -> rdata 0xDEADBEEF at its ready pulse.
3. Byte-enable merge:
   - Preload 0x11223344 at 0x20.
   - Store wdata 0xAA00BB00, be 1010 -> LW 0x20 returns 0xAA22BB44.
   - Store with be 0000 -> word unchanged, ready still pulses.
4. Out of range, DEPTH_WORDS=1024:
   - LW addr 0x1000 -> ready with err=1, rdata=0.
   - SW 0x1000 data 0xFFFFFFFF -> err=1; LW 0x0 unchanged (no aliasing).
5. Latency sweep, WAIT_STATES=0 and 3:
   - Ready at T+1 and T+4 respectively.
   - With req held continuously, ready pulses every 2 and 5 cycles.
   - busy low exactly one cycle between accesses.
6. Field-change robustness: change addr from 0x10 to 0x14 during WAIT -> access completes to 0x10; rdata holds the last load value across an intervening store.
